// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file write path.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } rfw_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the priority pointer, wrapping modulo N. The pointer register lives
// in the instantiating block.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_grant && req[IW'(idx)]) begin
        any_grant         = 1'b1;
        grant[IW'(idx)]   = 1'b1;
        grant_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port: clears x1..x31 after reset (or on
// request), then shares the port round-robin among NREQ writeback sources.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned NREQ     = 3,
  parameter int unsigned CLEAR_EN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*REG_ADDR_W-1:0]   req_addr,
  input  logic [NREQ*Width-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rf_RegWrite,
  output logic [REG_ADDR_W-1:0]        rf_W_Add,
  output logic [Width-1:0]             rf_W_Data,
  output logic                         init_done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_idx
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [REG_ADDR_W-1:0] CLR_LAST = REG_ADDR_W'(NUM_REGS - 1);
  localparam rfw_state_t INIT_STATE = (CLEAR_EN != 0) ? CLEAR : RUN;

  rfw_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_idx_q, grant_idx_d;

  logic [NREQ-1:0]        arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;
  logic [REG_ADDR_W-1:0]  sel_addr;
  logic [Width-1:0]       sel_data;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign grant_idx = grant_idx_q;

  // Route the granted requester's address/data slice.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IW'(j) == arb_idx) begin
        sel_addr = req_addr[j*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[j*Width +: Width];
      end
    end
  end

  // State, clear counter, round-robin pointer and last-grant registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT_STATE;
      clr_cnt_q   <= REG_ADDR_W'(1);
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Next-state and write-port outputs; everything is forced to 0 while reset
  // is held so the port is quiet even though the state register sits in CLEAR.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    req_ready   = '0;
    rf_RegWrite = 1'b0;
    rf_W_Add    = '0;
    rf_W_Data   = '0;
    init_done   = 1'b0;
    if (reset) begin
      case (state_q)
        CLEAR: begin
          rf_RegWrite = 1'b1;
          rf_W_Add    = clr_cnt_q;
          if (clr_cnt_q == CLR_LAST) begin
            clr_cnt_d = REG_ADDR_W'(1);
            state_d   = RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + REG_ADDR_W'(1);
          end
        end
        RUN: begin
          init_done = 1'b1;
          if (clear_req) begin
            state_d   = CLEAR;
            clr_cnt_d = REG_ADDR_W'(1);
          end else if (arb_any) begin
            req_ready   = arb_grant;
            rf_W_Add    = sel_addr;
            rf_W_Data   = sel_data;
            rf_RegWrite = (sel_addr != '0);
            grant_idx_d = arb_idx;
            rr_ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          end
        end
        default: state_d = INIT_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NREQ = 3, Width = 32).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_RegWrite;
  logic [4:0]  rf_W_Add;
  logic [31:0] rf_W_Data;
  logic        init_done;
  logic [1:0]  grant_idx;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(
    .Width    (32),
    .NREQ     (3),
    .CLEAR_EN (1)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .clear_req   (clear_req),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_RegWrite (rf_RegWrite),
    .rf_W_Add    (rf_W_Add),
    .rf_W_Data   (rf_W_Data),
    .init_done   (init_done),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_clear(input int unsigned k);
    chk($sformatf("clr_we_%0d", k), 32'(rf_RegWrite), 32'd1);
    chk($sformatf("clr_add_%0d", k), 32'(rf_W_Add), k);
    chk($sformatf("clr_data_%0d", k), rf_W_Data, 32'd0);
    chk($sformatf("clr_ready_%0d", k), 32'(req_ready), 32'd0);
    chk($sformatf("clr_done_%0d", k), 32'(init_done), 32'd0);
  endtask

  initial begin
    int exp_g [4];
    rst_n     = 1'b0;
    clear_req = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset state
    #3;
    chk("rst_we", 32'(rf_RegWrite), 32'd0);
    chk("rst_add", 32'(rf_W_Add), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gidx", 32'(grant_idx), 32'd0);

    // 1: clear sequence after reset release, requests ignored meanwhile
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 3'b001;
    req_addr  = 15'd4;
    #1;
    for (int unsigned k = 1; k <= 31; k++) begin
      chk_clear(k);
      @(negedge clk);
      if (k == 31) req_valid = '0;
      #1;
    end
    chk("run_done", 32'(init_done), 32'd1);
    chk("run_idle_we", 32'(rf_RegWrite), 32'd0);
    chk("run_idle_ready", 32'(req_ready), 32'd0);
    chk("run_idle_add", 32'(rf_W_Add), 32'd0);

    // 2: three requesters, round-robin 0,1,2
    @(negedge clk);
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    #1;
    chk("rr0_ready", 32'(req_ready), 32'b001);
    chk("rr0_add", 32'(rf_W_Add), 32'd5);
    chk("rr0_data", rf_W_Data, 32'hAAAA_0001);
    chk("rr0_we", 32'(rf_RegWrite), 32'd1);
    @(negedge clk);
    req_valid = 3'b110;
    #1;
    chk("rr1_gidx", 32'(grant_idx), 32'd0);
    chk("rr1_ready", 32'(req_ready), 32'b010);
    chk("rr1_add", 32'(rf_W_Add), 32'd6);
    chk("rr1_data", rf_W_Data, 32'hBBBB_0002);
    @(negedge clk);
    req_valid = 3'b100;
    #1;
    chk("rr2_gidx", 32'(grant_idx), 32'd1);
    chk("rr2_ready", 32'(req_ready), 32'b100);
    chk("rr2_add", 32'(rf_W_Add), 32'd7);
    chk("rr2_data", rf_W_Data, 32'hCCCC_0003);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("rr3_gidx", 32'(grant_idx), 32'd2);
    chk("rr3_ready", 32'(req_ready), 32'd0);
    chk("rr3_we", 32'(rf_RegWrite), 32'd0);
    chk("rr3_data", rf_W_Data, 32'd0);

    // 3: write to x0 accepted but dropped (pointer wrapped to 0 -> req1 wins)
    @(negedge clk);
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
    #1;
    chk("x0_ready", 32'(req_ready), 32'b010);
    chk("x0_we", 32'(rf_RegWrite), 32'd0);
    chk("x0_data", rf_W_Data, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("x0_gidx", 32'(grant_idx), 32'd1);

    // 4: req0 and req2 both held; pointer is at 2 so order is 2,0,2,0
    @(negedge clk);
    req_valid = 3'b101;
    req_addr  = {5'd11, 5'd0, 5'd10};
    req_data  = {32'h0000_2000, 32'd0, 32'h0000_1000};
    exp_g[0] = 2; exp_g[1] = 0; exp_g[2] = 2; exp_g[3] = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt%0d_ready", i), 32'(req_ready), 32'(3'b001 << exp_g[i]));
      chk($sformatf("alt%0d_add", i), 32'(rf_W_Add), (exp_g[i] == 2) ? 32'd11 : 32'd10);
      @(negedge clk);
      #1;
      chk($sformatf("alt%0d_gidx", i), 32'(grant_idx), 32'(exp_g[i]));
    end
    req_valid = 3'b000;

    // 5: clear_req while req0 valid; req0 served after the clear
    @(negedge clk);
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_data  = {32'd0, 32'd0, 32'h1234_5678};
    clear_req = 1'b1;
    #1;
    chk("clrq_ready", 32'(req_ready), 32'd0);
    chk("clrq_we", 32'(rf_RegWrite), 32'd0);
    chk("clrq_done", 32'(init_done), 32'd1);
    @(negedge clk);
    clear_req = 1'b0;
    #1;
    for (int unsigned k = 1; k <= 31; k++) begin
      chk_clear(k);
      @(negedge clk);
      #1;
    end
    chk("post_clr_done", 32'(init_done), 32'd1);
    chk("post_clr_ready", 32'(req_ready), 32'b001);
    chk("post_clr_add", 32'(rf_W_Add), 32'd9);
    chk("post_clr_data", rf_W_Data, 32'h1234_5678);
    chk("post_clr_we", 32'(rf_RegWrite), 32'd1);
    // pointer now 1 -> req1 wins
    @(negedge clk);
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd3, 5'd9};
    req_data  = {32'd0, 32'h0000_0055, 32'h1234_5678};
    #1;
    chk("g1_ready", 32'(req_ready), 32'b010);
    chk("g1_add", 32'(rf_W_Add), 32'd3);
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("g1_gidx", 32'(grant_idx), 32'd1);

    // 6: reset mid-clear at clr_cnt = 12
    @(negedge clk);
    clear_req = 1'b1;
    #1;
    @(negedge clk);
    clear_req = 1'b0;
    #1;
    for (int unsigned k = 1; k <= 12; k++) begin
      chk_clear(k);
      if (k != 12) begin
        @(negedge clk);
        #1;
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rf_RegWrite), 32'd0);
    chk("mid_rst_add", 32'(rf_W_Add), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_gidx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int unsigned k = 1; k <= 31; k++) begin
      chk_clear(k);
      @(negedge clk);
      #1;
    end
    chk("final_done", 32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
